// File: rtl/window_feeder.sv
// Window feeder: packs a character stream into N-lane windows for the
// matching engine, waits for the engine to settle, and reports the result.
module window_feeder #(
    parameter int CHARACTER_WIDTH = 8,
    parameter int CC_ID_BITS      = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [CHARACTER_WIDTH-1:0]                     in_data,
    input  logic                                           in_last,
    input  logic [(2**CC_ID_BITS)-1:0]                     elaborating_chars,
    input  logic                                           any_bb_accept,
    output logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]     cur_window,
    output logic [(2**CC_ID_BITS)-1:0]                     cur_window_enable,
    output logic [(2**CC_ID_BITS)-1:0]                     cur_window_end_of_s,
    output logic                                           new_char,
    output logic                                           done,
    output logic                                           accepted,
    output logic [COUNT_WIDTH-1:0]                         char_count
);

    localparam int N = 2**CC_ID_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [CC_ID_BITS-1:0]        idx_q, idx_d;
    logic [N*CHARACTER_WIDTH-1:0] win_q, win_d;
    logic [N-1:0]                 en_q, en_d;
    logic [N-1:0]                 eos_q, eos_d;
    logic                         acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                         first_q, first_d;

    logic hs;
    logic wait_exit;

    assign hs        = in_valid & in_ready;
    // The first WAIT cycle never exits: the engine needs a cycle to raise busy.
    assign wait_exit = (state_q == S_WAIT) && !first_q &&
                       (elaborating_chars == '0);

    assign cur_window          = win_q;
    assign cur_window_enable   = en_q;
    assign cur_window_end_of_s = eos_q;
    assign accepted            = acc_q;
    assign char_count          = cnt_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            win_q   <= '0;
            en_q    <= '0;
            eos_q   <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            en_q    <= en_d;
            eos_q   <= eos_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FILL;
            S_FILL:  if (hs && ((&idx_q) || in_last)) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_exit) begin
                    if (|eos_q)     state_d = S_DONE;
                    else if (acc_q) state_d = S_FLUSH;
                    else            state_d = S_FILL;
                end
            end
            S_FLUSH: if (hs && in_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        in_ready = 1'b0;
        new_char = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_FILL, S_FLUSH: in_ready = 1'b1;
            S_ISSUE:         new_char = 1'b1;
            S_DONE:          done     = 1'b1;
            default: ;
        endcase
    end

    // Window packing, match capture and saturating character count.
    always_comb begin
        idx_d   = idx_q;
        win_d   = win_q;
        en_d    = en_q;
        eos_d   = eos_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        first_d = (state_q == S_ISSUE);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d = '0;
                    win_d = '0;
                    en_d  = '0;
                    eos_d = '0;
                    acc_d = 1'b0;
                    cnt_d = '0;
                end
            end
            S_FILL: begin
                if (hs) begin
                    win_d[idx_q*CHARACTER_WIDTH +: CHARACTER_WIDTH] = in_data;
                    en_d[idx_q]  = 1'b1;
                    eos_d[idx_q] = in_last;
                    idx_d        = idx_q + CC_ID_BITS'(1);
                    if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
                end
            end
            S_WAIT: begin
                if (wait_exit && !(|eos_q) && !acc_q) begin
                    idx_d = '0;
                    en_d  = '0;
                    eos_d = '0;
                end
            end
            default: ;
        endcase
        if (any_bb_accept &&
            (state_q inside {S_FILL, S_ISSUE, S_WAIT}))
            acc_d = 1'b1;
    end

endmodule

// File: tb/tb_window_feeder.sv
// Self-checking bench for window_feeder (N=2, CW=8, 5-bit counter so
// saturation is reachable) against a string-level protocol model.
module tb_window_feeder;

    localparam int CW   = 8;
    localparam int CB   = 1;
    localparam int N    = 2;
    localparam int CNTW = 5;
    localparam int CMAX = (1 << CNTW) - 1;

    typedef enum int {P_FILL, P_ISSUE, P_WAIT, P_FLUSH, P_DONE, P_IDLE} ph_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW-1:0]   in_data = '0;
    logic            in_last = 1'b0;
    logic [N-1:0]    elaborating_chars = '0;
    logic            any_bb_accept = 1'b0;
    logic [N*CW-1:0] cur_window;
    logic [N-1:0]    cur_window_enable;
    logic [N-1:0]    cur_window_end_of_s;
    logic            new_char;
    logic            done;
    logic            accepted;
    logic [CNTW-1:0] char_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [CW-1:0] str_q[$];

    window_feeder #(
        .CHARACTER_WIDTH (CW),
        .CC_ID_BITS      (CB),
        .COUNT_WIDTH     (CNTW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .in_last             (in_last),
        .elaborating_chars   (elaborating_chars),
        .any_bb_accept       (any_bb_accept),
        .cur_window          (cur_window),
        .cur_window_enable   (cur_window_enable),
        .cur_window_end_of_s (cur_window_end_of_s),
        .new_char            (new_char),
        .done                (done),
        .accepted            (accepted),
        .char_count          (char_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [N*CW-1:0] masked(input logic [N*CW-1:0] w,
                                               input logic [N-1:0] en);
        logic [N*CW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (en[i]) r[i*CW +: CW] = w[i*CW +: CW];
        return r;
    endfunction

    task automatic check_window(input string tag, input logic [N*CW-1:0] ew,
                                input logic [N-1:0] een,
                                input logic [N-1:0] eeos);
        chk({tag, "_win"}, masked(cur_window, een), masked(ew, een));
        chk({tag, "_en"}, cur_window_enable, een);
        chk({tag, "_eos"}, cur_window_end_of_s, eeos);
    endtask

    // elab_mode: 0 = engine idle, 1 = random busy, 2 = busy for 5 WAIT cycles
    task automatic run_string(input int gap_pct, input int elab_mode,
                              input int acc_win, input int acc_cyc,
                              input bit spam, input bit rst_wait);
        int len, pos, lane, win, wait_n, cnt;
        bit acc, fin;
        ph_t ph;
        logic [N-1:0] e_en, e_eos;
        logic [N*CW-1:0] e_win;
        len = str_q.size();
        pos = 0; lane = 0; win = 0; wait_n = 0; cnt = 0;
        acc = 1'b0; fin = 1'b0; ph = P_FILL;
        e_en = '0; e_eos = '0; e_win = '0;
        chk("idle_ready", in_ready, 0);
        start = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            in_valid = 1'b0;
            in_last = 1'b0;
            any_bb_accept = 1'b0;
            start = 1'b0;
            elaborating_chars = (elab_mode == 1) ?
                N'($urandom_range(0, (1 << N) - 1)) : '0;
            case (ph)
                P_FILL: begin
                    chk("fill_ready", in_ready, 1);
                    chk("fill_newchar", new_char, 0);
                    chk("fill_done", done, 0);
                    in_valid = ($urandom_range(0, 99) >= gap_pct);
                    in_data = str_q[pos];
                    in_last = (pos == len - 1);
                    if (spam) start = 1'($urandom_range(0, 1));
                    if (in_valid) begin
                        e_win[lane*CW +: CW] = str_q[pos];
                        e_en[lane] = 1'b1;
                        e_eos[lane] = in_last;
                        if (cnt < CMAX) cnt++;
                        pos++;
                        if (lane == N - 1 || in_last) ph = P_ISSUE;
                        lane++;
                    end
                end
                P_ISSUE: begin
                    chk("issue_newchar", new_char, 1);
                    chk("issue_ready", in_ready, 0);
                    check_window("issue", e_win, e_en, e_eos);
                    ph = P_WAIT;
                    wait_n = 0;
                end
                P_WAIT: begin
                    chk("wait_ready", in_ready, 0);
                    chk("wait_newchar", new_char, 0);
                    chk("wait_done", done, 0);
                    check_window("wait", e_win, e_en, e_eos);
                    if (elab_mode == 2)
                        elaborating_chars = (wait_n < 5) ? N'(1) : '0;
                    if (rst_wait && wait_n == 1) begin
                        rst = 1'b0;
                        @(negedge clk);
                        chk("rst_ready", in_ready, 0);
                        chk("rst_newchar", new_char, 0);
                        chk("rst_done", done, 0);
                        chk("rst_win", cur_window, 0);
                        chk("rst_en", cur_window_enable, 0);
                        chk("rst_eos", cur_window_end_of_s, 0);
                        chk("rst_acc", accepted, 0);
                        chk("rst_cnt", char_count, 0);
                        rst = 1'b1;
                        fin = 1'b1;
                    end else begin
                        if (win == acc_win && wait_n == acc_cyc) begin
                            any_bb_accept = 1'b1;
                            acc = 1'b1;
                        end
                        if (spam) start = 1'($urandom_range(0, 1));
                        if (wait_n >= 1 && elaborating_chars == '0) begin
                            if (|e_eos) ph = P_DONE;
                            else if (acc) ph = P_FLUSH;
                            else begin
                                ph = P_FILL;
                                lane = 0;
                                e_en = '0;
                                e_eos = '0;
                                win++;
                            end
                        end else begin
                            wait_n++;
                        end
                    end
                end
                P_FLUSH: begin
                    chk("flush_ready", in_ready, 1);
                    chk("flush_newchar", new_char, 0);
                    chk("flush_done", done, 0);
                    in_valid = ($urandom_range(0, 99) >= gap_pct);
                    in_data = str_q[pos];
                    in_last = (pos == len - 1);
                    if (in_valid) begin
                        pos++;
                        if (in_last) ph = P_DONE;
                    end
                end
                P_DONE: begin
                    chk("done_pulse", done, 1);
                    chk("done_acc", accepted, acc);
                    chk("done_cnt", char_count, cnt);
                    chk("done_ready", in_ready, 0);
                    chk("done_newchar", new_char, 0);
                    ph = P_IDLE;
                end
                default: begin
                    chk("post_done", done, 0);
                    chk("post_acc", accepted, acc);
                    chk("post_cnt", char_count, cnt);
                    chk("post_ready", in_ready, 0);
                    fin = 1'b1;
                end
            endcase
            if (!fin) @(negedge clk);
        end
        chk("finished", fin, 1);
    endtask

    task automatic load_rand(input int len);
        str_q.delete();
        for (int i = 0; i < len; i++) str_q.push_back(CW'($urandom));
    endtask

    initial begin
        int len, aw;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", in_ready, 0);
        chk("reset_newchar", new_char, 0);
        chk("reset_done", done, 0);
        chk("reset_win", cur_window, 0);
        chk("reset_en", cur_window_enable, 0);
        chk("reset_eos", cur_window_end_of_s, 0);
        chk("reset_acc", accepted, 0);
        chk("reset_cnt", char_count, 0);
        rst = 1'b1;
        @(negedge clk);

        str_q = '{8'h61, 8'h62, 8'h63};
        run_string(0, 0, -1, 0, 1'b0, 1'b0);

        str_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        run_string(0, 2, -1, 0, 1'b0, 1'b0);

        load_rand(6);
        run_string(0, 0, 0, 0, 1'b0, 1'b0);

        str_q = '{8'h61, 8'h62, 8'h63};
        run_string(0, 0, 1, 1, 1'b0, 1'b0);

        str_q = '{8'h78, 8'h79, 8'h7a, 8'h77};
        run_string(0, 2, -1, 0, 1'b0, 1'b1);
        str_q = '{8'h61, 8'h62, 8'h63};
        run_string(0, 0, -1, 0, 1'b0, 1'b0);

        str_q = '{8'h7a};
        run_string(0, 1, -1, 0, 1'b1, 1'b0);

        load_rand(40);
        run_string(20, 0, -1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(1, 9);
            load_rand(len);
            aw = ($urandom_range(0, 2) == 0) ?
                 $urandom_range(0, (len - 1) / N) : -1;
            run_string(30, 1, aw, 0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
